// File: rtl/mac_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : mac_tx_arb
// Purpose  : Round-robin arbiter that merges N_PORTS AXI-Stream requesters
//            into one frame-granular stream toward a MAC TX controller.
//            A frame whose source stalls mid-frame (underrun) is aborted:
//            the remainder of that frame is sunk and counted as a drop.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk, i_reset_n   clock / asynchronous active-low reset
//   i_clk_en           global clock enable (registers and handshakes)
//   i_port_en          per-port arbitration enable
//   s_t*               per-port AXI-S slave side (flattened, port 0 in LSBs)
//   m_t*               AXI-S master side
//   o_grant            registered one-hot grant, zero when idle
//   o_busy             high while a frame is being passed or dropped
//   o_underrun         one-cycle pulse after a mid-frame underrun
//   o_drop_cnt         saturating count of aborted frames
// ============================================================================
module mac_tx_arb #(
  parameter int N_PORTS   = 2,
  parameter int N_SYMBOLS = 4,
  parameter int W_SYMBOL  = 8
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_clk_en,
  input  logic [N_PORTS-1:0]                    i_port_en,
  input  logic [N_PORTS-1:0]                    s_tvalid,
  input  logic [N_PORTS-1:0]                    s_tlast,
  input  logic [N_PORTS*N_SYMBOLS*W_SYMBOL-1:0] s_tdata,
  input  logic [N_PORTS*N_SYMBOLS-1:0]          s_tkeep,
  output logic [N_PORTS-1:0]                    s_tready,
  output logic                                  m_tvalid,
  output logic                                  m_tlast,
  output logic [N_SYMBOLS*W_SYMBOL-1:0]         m_tdata,
  output logic [N_SYMBOLS-1:0]                  m_tkeep,
  input  logic                                  m_tready,
  output logic [N_PORTS-1:0]                    o_grant,
  output logic                                  o_busy,
  output logic                                  o_underrun,
  output logic [15:0]                           o_drop_cnt
);

  localparam int          DW = N_SYMBOLS * W_SYMBOL;
  localparam int          IW = $clog2(N_PORTS);
  localparam logic [IW:0] NP = (IW+1)'(N_PORTS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state;
  logic [IW-1:0]      q_last;     // last port served; search starts after it
  logic [IW-1:0]      g_idx;      // binary index of the granted port
  logic               q_in_frame;
  logic               underrun_q;

  logic [N_PORTS-1:0] req;
  logic               req_any;
  logic [IW-1:0]      pick_idx;
  logic [N_PORTS-1:0] pick_oh;
  logic [IW:0]        rr_sum;

  logic               g_valid;
  logic               g_last;
  logic               pass_acc;
  logic               underrun_cond;
  logic               drop_acc;

  assign req = s_tvalid & i_port_en;

  // Round-robin search: q_last+1, q_last+2, ... wrapping modulo N_PORTS.
  always_comb begin
    req_any  = 1'b0;
    pick_idx = '0;
    pick_oh  = '0;
    rr_sum   = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      rr_sum = {1'b0, q_last} + (IW+1)'(i);
      if (rr_sum >= NP) rr_sum = rr_sum - NP;
      if (!req_any && req[rr_sum[IW-1:0]]) begin
        req_any                   = 1'b1;
        pick_idx                  = rr_sum[IW-1:0];
        pick_oh[rr_sum[IW-1:0]]   = 1'b1;
      end
    end
  end

  assign g_valid = s_tvalid[g_idx];
  assign g_last  = s_tlast[g_idx];

  // Data path always follows the granted port; only valid/ready are gated.
  assign m_tdata = s_tdata[int'(g_idx)*DW +: DW];
  assign m_tkeep = s_tkeep[int'(g_idx)*N_SYMBOLS +: N_SYMBOLS];
  assign m_tlast = g_last;

  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    case (state)
      PASS: begin
        s_tready[g_idx] = m_tready & i_clk_en;
        m_tvalid        = g_valid;
      end
      DROP: s_tready[g_idx] = i_clk_en;   // sink the rest of the frame
      default: ;
    endcase
  end

  assign pass_acc      = (state == PASS) && g_valid && m_tready && i_clk_en;
  assign underrun_cond = (state == PASS) && q_in_frame && m_tready && i_clk_en && !g_valid;
  assign drop_acc      = (state == DROP) && g_valid && i_clk_en;

  // The pulse register holds while the clock is disabled, so mask it there.
  assign o_underrun = underrun_q & i_clk_en;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_grant    <= '0;
      g_idx      <= '0;
      q_last     <= IW'(N_PORTS - 1);
      q_in_frame <= 1'b0;
      o_busy     <= 1'b0;
      underrun_q <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_clk_en) begin
      underrun_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            o_grant <= pick_oh;
            g_idx   <= pick_idx;
            o_busy  <= 1'b1;
            state   <= PASS;
          end
        end
        PASS: begin
          if (pass_acc) begin
            if (g_last) begin
              q_last     <= g_idx;
              o_grant    <= '0;
              q_in_frame <= 1'b0;
              o_busy     <= 1'b0;
              state      <= IDLE;
            end else begin
              q_in_frame <= 1'b1;
            end
          end else if (underrun_cond) begin
            underrun_q <= 1'b1;
            if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
            state      <= DROP;
          end
        end
        DROP: begin
          if (drop_acc && g_last) begin
            q_last     <= g_idx;
            o_grant    <= '0;
            q_in_frame <= 1'b0;
            o_busy     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          o_grant <= '0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mac_tx_arb.md
MAC_TX_ARB -- requirements
Module: mac_tx_arb

Interface
REQ-001 Parameter N_PORTS, default 2: number of AXI-Stream requester ports, range 2..8.
REQ-002 Parameter N_SYMBOLS, default 4: symbols per beat.
REQ-003 Parameter W_SYMBOL, default 8: bits per symbol.
REQ-004 Port i_clk  in  1: the single clock; all registers are rising-edge.
REQ-005 Port i_reset_n  in  1: asynchronous active-low reset.
REQ-006 Port i_clk_en  in  1: clock enable; registers update only when it is 1.
REQ-007 Port i_port_en  in  N_PORTS: per-port arbitration enable.
REQ-008 Port s_tvalid / s_tlast  in  N_PORTS each: per-port AXI-S valid and last.
REQ-009 Port s_tdata  in  N_PORTS x N_SYMBOLS x W_SYMBOL: per-port data.
REQ-010 Port s_tkeep  in  N_PORTS x N_SYMBOLS: per-port keep.
REQ-011 Port s_tready  out  N_PORTS: per-port ready.
REQ-012 Port m_tvalid / m_tlast  out  1 each: master valid and last, toward the MAC TX controller.
REQ-013 Port m_tdata  out  N_SYMBOLS x W_SYMBOL, and port m_tkeep  out  N_SYMBOLS: master data and keep.
REQ-014 Port m_tready  in  1: master ready.
REQ-015 Port o_grant  out  N_PORTS: registered one-hot grant; all-zero when no port is granted.
REQ-016 Port o_busy  out  1: high in the PASS and DROP states.
REQ-017 Port o_underrun  out  1: one-cycle pulse on a mid-frame underrun.
REQ-018 Port o_drop_cnt  out  16: saturating count of aborted frames.

Function
REQ-019 The FSM SHALL have three states: IDLE, PASS and DROP.
REQ-020 Arbitration in IDLE:
- Req = s_tvalid & i_port_en.
- If Req is non-zero, the block SHALL grant the first requesting port found cyclically starting at q_last+1 (round-robin).
- On grant it SHALL load o_grant and move to PASS.
- Arbitration latency is one cycle from request to first possible transfer.
REQ-021 In IDLE, all s_tready bits and m_tvalid SHALL be 0.
REQ-022 In PASS, for granted port g, the master outputs SHALL be combinational pass-through:
- m_tvalid = s_tvalid[g]; m_tdata, m_tkeep and m_tlast come from port g.
- s_tready[g] = m_tready & i_clk_en.
- All other s_tready bits = 0.
REQ-023 In PASS, an accepted beat with m_tlast = 1 SHALL:
- set q_last = g;
- clear o_grant;
- return the FSM to IDLE on the next enabled edge.
REQ-024 In PASS, q_in_frame SHALL set on the first accepted beat and clear on tlast.
REQ-025 Underrun condition: in PASS, q_in_frame = 1, m_tready = 1, i_clk_en = 1 and s_tvalid[g] = 0.
REQ-026 On underrun the block SHALL pulse o_underrun, increment o_drop_cnt (saturating at 0xFFFF) and move to DROP.
REQ-027 In DROP:
- m_tvalid = 0.
- s_tready[g] = i_clk_en, so the port is sunk.
- An accepted beat with s_tlast[g] SHALL set q_last = g, clear o_grant and return the FSM to IDLE.
REQ-028 Clearing i_port_en[g] while in PASS or DROP SHALL NOT affect the current frame; the bit applies only at the next arbitration.
REQ-029 Beats with tvalid & ready & tlast and tkeep = 0 SHALL be passed or sunk like any other last beat.
REQ-030 When i_clk_en = 0:
- All state, counters and pulses SHALL hold.
- o_underrun SHALL be 0.
- All s_tready bits SHALL be 0.
REQ-031 A tlast handshake and a new request in the same cycle SHALL produce no grant that cycle; arbitration happens in the following IDLE cycle.

Reset
REQ-032 While i_reset_n = 0 the block SHALL asynchronously force:
- state = IDLE;
- o_grant = 0, q_last = N_PORTS-1, q_in_frame = 0;
- o_busy = 0, o_underrun = 0, o_drop_cnt = 0;
- m_tvalid = 0 and s_tready = 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without an underrun pulse or a drop count.
REQ-034 After release, the first arbitration SHALL favour port 0.

Verification
REQ-035 Ports 0 and 1 request together after reset, each sending 3-beat frames, m_tready = 1 -> grants alternate 0,1,0,1; one idle cycle between frames; no beat lost or reordered.
REQ-036 Port 1 only, i_port_en = 2'b01 -> no grant and s_tready = 0; setting i_port_en = 2'b11 -> port 1 granted next cycle.
REQ-037 Port 0 sends beat 1, then s_tvalid[0] = 0 with m_tready = 1 -> o_underrun pulses once; o_drop_cnt = 1; m_tvalid stays 0 until port 0's tlast beat is sunk; the FSM returns to IDLE.
REQ-038 m_tready held at 0 for 10 cycles mid-frame -> data is held stable, no underrun, and the grant is unchanged.
REQ-039 i_reset_n pulsed low during PASS -> o_grant = 0 and m_tvalid = 0 immediately; o_drop_cnt unchanged at 0; the next grant goes to port 0.
REQ-040 i_clk_en toggling 1010 during a 4-beat frame -> transfers occur only on enabled cycles; the frame completes in 8 cycles with no underrun.
